q3_serial_sequencer: RTL and testbench

//  Sequencer wrapped around the 5-state q3 Moore FSM datapath: {y[2:0],x} -> next state, z.

---
 rtl/q3_pkg.sv | 17 +
 rtl/q3_serial_sequencer_if.sv | 26 ++
 rtl/q3_next_state.sv | 34 +++
 rtl/q3_serial_sequencer.sv | 84 ++++++++
 tb/tb_q3_serial_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/q3_pkg.sv
// Shared encodings for the q3 serial sequencer: FSM state codes and
// controller phases.
package q3_pkg;

    localparam logic [2:0] S000 = 3'b000;
    localparam logic [2:0] S001 = 3'b001;
    localparam logic [2:0] S010 = 3'b010;
    localparam logic [2:0] S011 = 3'b011;
    localparam logic [2:0] S100 = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ctl_t;

endpackage

// File: rtl/q3_serial_sequencer_if.sv
// Word-in / result-out handshake bundle. The sequencer sits on the slave
// modport; the producer/consumer side uses master.
interface q3_serial_sequencer_if #(
    parameter int W = 8
);
    localparam int ZW = $clog2(W + 1);

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [ZW-1:0] out_zcount;
    logic [2:0]    out_state;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_zcount, out_state
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_zcount, out_state
    );

endinterface

// File: rtl/q3_next_state.sv
// Combinational next-state / Moore output of the 5-state q3 FSM.
// Unused codes 101..111 recover to 000 with z=0.
module q3_next_state
    import q3_pkg::*;
(
    input  logic [2:0] y_i,
    input  logic       x_i,
    output logic [2:0] y_o,
    output logic       z_o
);

    always_comb begin
        y_o = S000;
        z_o = 1'b0;
        case (y_i)
            S000: y_o = x_i ? S001 : S000;
            S001: y_o = x_i ? S100 : S001;
            S010: y_o = x_i ? S001 : S010;
            S011: begin
                y_o = x_i ? S010 : S001;
                z_o = 1'b1;
            end
            S100: begin
                y_o = x_i ? S100 : S011;
                z_o = 1'b1;
            end
            default: begin
                y_o = S000;
                z_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/q3_serial_sequencer.sv
// Feeds a W-bit word LSB-first into the q3 FSM and returns {z count, final state}.
//   state | meaning
//   IDLE  | waiting for a word, in_ready=1
//   SHIFT | applying one bit per clock for W clocks
//   DONE  | result held on out_* until out_ready
module q3_serial_sequencer
    import q3_pkg::*;
#(
    parameter int W       = 8,
    parameter bit RESTART = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    q3_serial_sequencer_if.slave  bus,
    output logic [2:0]            fsm_state,
    output logic                  fsm_z
);

    localparam int CW = $clog2(W);
    localparam int ZW = $clog2(W + 1);

    ctl_t          ctl_q;
    logic [W-1:0]  shreg_q;
    logic [CW-1:0] bit_cnt_q;
    logic [ZW-1:0] zcount_q;
    logic [2:0]    fsm_q;
    logic [2:0]    fsm_d;
    logic          z;

    q3_next_state u_next_state (
        .y_i (fsm_q),
        .x_i (shreg_q[0]),
        .y_o (fsm_d),
        .z_o (z)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ctl_q     <= IDLE;
            fsm_q     <= S000;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            zcount_q  <= '0;
        end else begin
            case (ctl_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        shreg_q   <= bus.in_data;
                        bit_cnt_q <= '0;
                        zcount_q  <= '0;
                        if (RESTART) begin
                            fsm_q <= S000;
                        end
                        ctl_q     <= SHIFT;
                    end
                end
                SHIFT: begin
                    // z is taken from the state before this bit is applied
                    fsm_q     <= fsm_d;
                    zcount_q  <= zcount_q + ZW'(z);
                    shreg_q   <= shreg_q >> 1;
                    bit_cnt_q <= bit_cnt_q + CW'(1);
                    if (bit_cnt_q == CW'(W - 1)) begin
                        ctl_q <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        ctl_q <= IDLE;
                    end
                end
                default: ctl_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (ctl_q == IDLE);
    assign bus.out_valid  = (ctl_q == DONE);
    assign bus.out_zcount = zcount_q;
    assign bus.out_state  = fsm_q;
    assign fsm_state      = fsm_q;
    assign fsm_z          = z;

endmodule

// File: tb/tb_q3_serial_sequencer.sv
// Self-checking bench for q3_serial_sequencer (W=8) with a RESTART=0 twin
// and a standalone next-state decoder instance.
module tb_q3_serial_sequencer;

    localparam int W = 8;

    typedef struct packed {
        logic [3:0] zc;
        logic [2:0] st;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic [3:0] zc;
        logic [2:0] st;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   vec_cnt = 0;
    int   miss_cnt = 0;
    exp_t sb_q[$];
    vec_t tbl[6];

    logic [2:0] fsm_state, fsm_state_nr;
    logic       fsm_z, fsm_z_nr;
    logic [2:0] ns_y, ns_ny;
    logic       ns_x, ns_z;

    q3_serial_sequencer_if #(.W(W)) bi();
    q3_serial_sequencer_if #(.W(W)) bn();

    q3_serial_sequencer #(.W(W), .RESTART(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bi),
        .fsm_state (fsm_state),
        .fsm_z     (fsm_z)
    );

    q3_serial_sequencer #(.W(W), .RESTART(1'b0)) dut_nr (
        .clk       (clk),
        .reset     (reset),
        .bus       (bn),
        .fsm_state (fsm_state_nr),
        .fsm_z     (fsm_z_nr)
    );

    q3_next_state u_ns (
        .y_i (ns_y),
        .x_i (ns_x),
        .y_o (ns_ny),
        .z_o (ns_z)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard: results popped and compared whenever the consumer takes one.
    always @(negedge clk) begin
        if (!reset && bi.out_valid && bi.out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_out_zcount", int'(bi.out_zcount), int'(e.zc));
                check("sb_out_state", int'(bi.out_state), int'(e.st));
            end
        end
    end

    task automatic send(input vec_t v, output int acc);
        int n;
        n = 0;
        acc = -1;
        @(negedge clk);
        bi.in_valid = 1'b1;
        bi.in_data  = v.data;
        while (!bi.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bi.in_ready) begin
            check("send_timeout", 0, 1);
        end else begin
            sb_q.push_back('{zc: v.zc, st: v.st});
            acc = cyc;
        end
        @(posedge clk);
        #1 bi.in_valid = 1'b0;
    endtask

    task automatic wait_result(input int acc, input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!bi.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_out_valid"}, int'(bi.out_valid), 1);
        if (bi.out_valid) begin
            check({nm, "_latency"}, cyc - acc, W + 1);
            @(posedge clk);
            #1 bi.out_ready = 1'b1;
            @(negedge clk);
            @(posedge clk);
            #1 bi.out_ready = 1'b0;
            @(negedge clk);
            check({nm, "_valid_drop"}, int'(bi.out_valid), 0);
            check({nm, "_ready_back"}, int'(bi.in_ready), 1);
        end
    endtask

    task automatic nr_word(input logic [7:0] d, output int first_st, output int zc, output int st);
        int n;
        n = 0;
        @(negedge clk);
        bn.in_valid = 1'b1;
        bn.in_data  = d;
        @(posedge clk);
        #1 bn.in_valid = 1'b0;
        @(negedge clk);
        first_st = int'(fsm_state_nr);
        while (!bn.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        zc = int'(bn.out_zcount);
        st = int'(bn.out_state);
        check("nr_out_valid", int'(bn.out_valid), 1);
        @(posedge clk);
        #1 bn.out_ready = 1'b1;
        @(posedge clk);
        #1 bn.out_ready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] nx0 [8];
        logic [2:0] nx1 [8];
        logic       zz  [8];
        logic [2:0] st03 [8];
        int acc, first_st, zc, st;
        int accs [4];
        int k;
        bit saw;

        tbl[0] = '{data: 8'h03, zc: 4'd2, st: 3'b001};
        tbl[1] = '{data: 8'hFF, zc: 4'd6, st: 3'b100};
        tbl[2] = '{data: 8'h00, zc: 4'd0, st: 3'b000};
        tbl[3] = '{data: 8'h55, zc: 4'd2, st: 3'b001};
        tbl[4] = '{data: 8'h0F, zc: 4'd4, st: 3'b001};
        tbl[5] = '{data: 8'h06, zc: 4'd2, st: 3'b001};

        nx0  = '{3'd0, 3'd1, 3'd2, 3'd1, 3'd3, 3'd0, 3'd0, 3'd0};
        nx1  = '{3'd1, 3'd4, 3'd1, 3'd2, 3'd4, 3'd0, 3'd0, 3'd0};
        zz   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        st03 = '{3'd0, 3'd1, 3'd4, 3'd3, 3'd1, 3'd1, 3'd1, 3'd1};

        bi.in_valid = 1'b0; bi.in_data = '0; bi.out_ready = 1'b0;
        bn.in_valid = 1'b0; bn.in_data = '0; bn.out_ready = 1'b0;
        ns_y = 3'd0; ns_x = 1'b0;

        // Next-state table including recovery from the unused codes
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 2; x++) begin
                ns_y = 3'(y);
                ns_x = 1'(x);
                #1;
                check($sformatf("ns_next_y%0d_x%0d", y, x), int'(ns_ny),
                      int'(x != 0 ? nx1[y] : nx0[y]));
                check($sformatf("ns_z_y%0d", y), int'(ns_z), int'(zz[y]));
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(bi.in_ready), 1);
        check("rst_out_valid", int'(bi.out_valid), 0);
        check("rst_out_zcount", int'(bi.out_zcount), 0);
        check("rst_out_state", int'(bi.out_state), 0);
        check("rst_fsm_state", int'(fsm_state), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Live state trace for 8'h03
        send(tbl[0], acc);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check($sformatf("trace03_state_%0d", i), int'(fsm_state), int'(st03[i]));
            check($sformatf("trace03_z_%0d", i), int'(fsm_z), int'(zz[st03[i]]));
        end
        wait_result(acc, "trace03");

        for (int i = 0; i < 6; i++) begin
            send(tbl[i], acc);
            wait_result(acc, $sformatf("vec%0d", i));
        end

        // Consumer stalls in DONE while the producer pokes in_valid
        send(tbl[1], acc);
        k = 0;
        while (!bi.out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            bi.in_valid = 1'(i % 2);
            bi.in_data  = 8'h00;
            @(negedge clk);
            check("stall_out_valid", int'(bi.out_valid), 1);
            check("stall_in_ready", int'(bi.in_ready), 0);
            check("stall_zcount", int'(bi.out_zcount), 6);
            check("stall_state", int'(bi.out_state), 4);
        end
        @(posedge clk);
        #1 bi.in_valid = 1'b0; bi.out_ready = 1'b1;
        @(posedge clk);
        #1 bi.out_ready = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (bi.out_valid || !bi.in_ready) saw = 1'b1;
        end
        check("stall_no_extra_accept", int'(saw), 0);
        check("stall_fsm_kept", int'(fsm_state), 4);

        // Reset during the 4th shift cycle discards the word
        send(tbl[1], acc);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        void'(sb_q.pop_back());
        @(negedge clk);
        check("midrst_in_ready", int'(bi.in_ready), 1);
        check("midrst_out_valid", int'(bi.out_valid), 0);
        check("midrst_fsm_state", int'(fsm_state), 0);
        check("midrst_zcount", int'(bi.out_zcount), 0);
        saw = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (bi.out_valid) saw = 1'b1;
        end
        check("midrst_no_result", int'(saw), 0);

        // RESTART=0: state carries into the next word
        nr_word(8'h01, first_st, zc, st);
        check("nr1_first_state", first_st, 0);
        check("nr1_zcount", zc, 0);
        check("nr1_state", st, 1);
        nr_word(8'h01, first_st, zc, st);
        check("nr2_first_state", first_st, 1);
        check("nr2_zcount", zc, 2);
        check("nr2_state", st, 1);

        // Back-to-back words with both sides always ready
        @(posedge clk);
        #1;
        bi.in_valid  = 1'b1;
        bi.in_data   = tbl[2].data;
        bi.out_ready = 1'b1;
        k = 0;
        for (int n = 0; n < 80 && k < 4; n++) begin
            @(negedge clk);
            if (bi.in_ready) begin
                sb_q.push_back('{zc: tbl[k + 2].zc, st: tbl[k + 2].st});
                accs[k] = cyc;
                k++;
                @(posedge clk);
                #1;
                if (k < 4) bi.in_data = tbl[k + 2].data;
                else       bi.in_valid = 1'b0;
            end
        end
        check("b2b_accepts", k, 4);
        for (int i = 0; i < 3; i++) begin
            if (i + 1 < k) check($sformatf("b2b_period_%0d", i), accs[i + 1] - accs[i], W + 2);
        end
        repeat (2 * W) @(negedge clk);
        bi.out_ready = 1'b0;
        check("sb_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
